sha3_padder: RTL and testbench

SHA3_PADDER -- requirements
Module: sha3_padder

---
 rtl/sha3_padder_pkg.sv | 18 +
 rtl/sha3_pad_word.sv | 45 ++++
 rtl/sha3_padder.sv | 113 +++++++++++
 tb/tb_sha3_padder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_padder_pkg.sv
// Shared constants and state encoding for the SHA-3 (Keccak) message padder.
package sha3_padder_pkg;

  // Words of 32 bits per rate block: 18 words = 576 bits for Keccak-512.
  localparam int RATE_WORDS = 18;

  // Keccak multi-rate padding: 0x01 right after the message, 0x80 in the
  // last byte of the block (both land in one byte when they coincide).
  localparam logic [7:0] PAD_START_BYTE = 8'h01;
  localparam logic [7:0] PAD_END_BYTE   = 8'h80;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_PAD    = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sha3_pad_word.sv
// Builds the final message word: keeps the valid leading bytes, inserts the
// start-of-padding byte after them and, when the word closes the block,
// also sets the end-of-padding bit in the lowest byte.
module sha3_pad_word
  import sha3_padder_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  byte_num,
  input  logic        is_final,
  output logic [31:0] word_out
);

  logic [31:0] keep_mask;
  logic [31:0] start_word;

  // Select which message bytes survive and where the 0x01 byte goes; byte 0
  // is the most significant byte, so the pad byte moves down as k grows.
  always_comb begin
    keep_mask  = 32'h0000_0000;
    start_word = 32'h0000_0000;
    case (byte_num)
      2'd0: begin
        keep_mask  = 32'h0000_0000;
        start_word = {PAD_START_BYTE, 24'h00_0000};
      end
      2'd1: begin
        keep_mask  = 32'hFF00_0000;
        start_word = {8'h00, PAD_START_BYTE, 16'h0000};
      end
      2'd2: begin
        keep_mask  = 32'hFFFF_0000;
        start_word = {16'h0000, PAD_START_BYTE, 8'h00};
      end
      default: begin
        keep_mask  = 32'hFFFF_FF00;
        start_word = {24'h00_0000, PAD_START_BYTE};
      end
    endcase
    word_out = (data_in & keep_mask) | start_word;
    if (is_final) begin
      word_out[7:0] = word_out[7:0] | PAD_END_BYTE;
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// Collects 32-bit message words into a rate block for the Keccak permutation
// and appends multi-rate padding after the final word.
module sha3_padder
  import sha3_padder_pkg::*;
#(
  parameter int RATE_WORDS_P = RATE_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               in,
  input  logic                      in_ready,
  input  logic                      is_last,
  input  logic [1:0]                byte_num,
  input  logic                      f_ack,
  output logic                      buffer_full,
  output logic [32*RATE_WORDS_P-1:0] out
);

  localparam int OUT_W = 32 * RATE_WORDS_P;
  localparam int CNT_W = (RATE_WORDS_P > 1) ? $clog2(RATE_WORDS_P) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATE_WORDS_P - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;

  logic               last_pos;
  logic               shift_en;
  logic [31:0]        shift_word;
  logic [31:0]        pad_word;

  assign last_pos    = (cnt_q == LAST_CNT);
  assign buffer_full = full_q;
  assign out         = out_q;

  sha3_pad_word u_pad_word (
    .data_in  (in),
    .byte_num (byte_num),
    .is_final (last_pos),
    .word_out (pad_word)
  );

  // Next-state logic: decide whether a word shifts in this cycle and which
  // word it is, then advance the counter and raise buffer_full on wrap.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shift_en   = 1'b0;
    shift_word = 32'h0000_0000;

    case (state_q)
      ST_ACCEPT: begin
        if (in_ready && !full_q) begin
          shift_en   = 1'b1;
          shift_word = is_last ? pad_word : in;
          if (is_last) begin
            state_d = last_pos ? ST_DONE : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (!full_q) begin
          shift_en   = 1'b1;
          shift_word = last_pos ? {24'h00_0000, PAD_END_BYTE} : 32'h0000_0000;
          if (last_pos) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase

    // An acknowledge only releases a held block; words never shift while
    // full, so a word offered in the same cycle is dropped.
    if (full_q && f_ack) begin
      full_d = 1'b0;
    end

    if (shift_en) begin
      out_d = (out_q << 32) | OUT_W'(shift_word);
      if (last_pos) begin
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
      out_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Scoreboard bench for sha3_padder: expected blocks are queued when a
// message is issued and compared whenever buffer_full rises.
module tb_sha3_padder;

  localparam int RW = 18;
  localparam int OW = 32 * RW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   in_w = 32'h0;
  logic          in_ready = 1'b0;
  logic          is_last = 1'b0;
  logic [1:0]    byte_num = 2'd0;
  logic          f_ack = 1'b0;
  logic          buffer_full;
  logic [OW-1:0] out_w;

  logic [OW-1:0] expQ[$];
  string         nameQ[$];
  int            compared = 0;
  int            mismatched = 0;
  logic          full_prev = 1'b0;

  sha3_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_w),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .f_ack       (f_ack),
    .buffer_full (buffer_full),
    .out         (out_w)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] setWord(input logic [OW-1:0] b, input int idx,
                                            input logic [31:0] v);
    b[32*(RW-1-idx) +: 32] = v;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [OW-1:0] act,
                             input logic [OW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input string name, input logic [OW-1:0] blk);
    expQ.push_back(blk);
    nameQ.push_back(name);
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_ready = 1'b0;
    f_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic last, input logic [1:0] k);
    in_w = w;
    is_last = last;
    byte_num = k;
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    is_last = 1'b0;
  endtask

  task automatic waitFull(input string name, output int n);
    n = 0;
    while (buffer_full !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (buffer_full !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: buffer_full=%b after %0d cycles, want 1", name, buffer_full, n);
    end
  endtask

  task automatic ackBlock();
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
  endtask

  // Monitor: on every rising edge of buffer_full, pop the oldest expected
  // block and compare it with the presented output.
  always @(negedge clk) begin
    if (buffer_full === 1'b1 && full_prev !== 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_block: got %0h, want no block", out_w);
      end else begin
        checkOutput(nameQ.pop_front(), out_w, expQ.pop_front());
      end
    end
    full_prev = buffer_full;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int n;
    logic [OW-1:0] blk;
    logic [OW-1:0] blk1;

    @(posedge clk); #1;
    checkOutput("reset_out", out_w, '0);
    checkOutput("reset_full", OW'(buffer_full), '0);
    reset = 1'b0;

    $display("[TB] empty message");
    blk = '0;
    blk = setWord(blk, 0, 32'h0100_0000);
    blk = setWord(blk, 17, 32'h0000_0080);
    pushExpected("s1_block", blk);
    applyStimulus(32'hDEAD_BEEF, 1'b1, 2'd0);
    waitFull("s1", n);
    checkOutput("s1_latency", OW'(n), OW'(17));
    ackBlock();
    checkOutput("s1_ack_clear", OW'(buffer_full), '0);

    $display("[TB] short message");
    doReset();
    blk = '0;
    blk = setWord(blk, 0, 32'h6162_6301);
    blk = setWord(blk, 17, 32'h0000_0080);
    pushExpected("s2_block", blk);
    applyStimulus(32'h6162_63FF, 1'b1, 2'd3);
    waitFull("s2", n);
    ackBlock();

    $display("[TB] last word at final position");
    doReset();
    blk = '0;
    for (int i = 0; i < 17; i++) blk = setWord(blk, i, 32'h1111_1111);
    blk = setWord(blk, 17, 32'hAABB_CC81);
    pushExpected("s3_block", blk);
    for (int i = 0; i < 17; i++) applyStimulus(32'h1111_1111, 1'b0, 2'(i));
    applyStimulus(32'hAABB_CCDD, 1'b1, 2'd3);
    checkOutput("s3_full_next", OW'(buffer_full), OW'(1));
    ackBlock();
    applyStimulus(32'h5555_5555, 1'b1, 2'd0);
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("s3_done_full", OW'(buffer_full), '0);
    checkOutput("s3_done_hold", out_w, blk);

    $display("[TB] multi-block with backpressure");
    doReset();
    blk = '0;
    for (int i = 0; i < 18; i++) blk = setWord(blk, i, 32'(i + 1));
    blk1 = blk;
    pushExpected("s4_block1", blk1);
    for (int i = 0; i < 18; i++) applyStimulus(32'(i + 1), 1'b0, 2'(i));
    checkOutput("s4_full", OW'(buffer_full), OW'(1));
    blk = '0;
    blk = setWord(blk, 0, 32'h13AA_0100);
    blk = setWord(blk, 17, 32'h0000_0080);
    pushExpected("s4_block2", blk);
    in_w = 32'h13AA_BBCC;
    is_last = 1'b1;
    byte_num = 2'd2;
    in_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("s4_hold_full", OW'(buffer_full), OW'(1));
    end
    checkOutput("s4_hold_out", out_w, blk1);
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
    checkOutput("s6_full_clear", OW'(buffer_full), '0);
    checkOutput("s6_out_hold", out_w, blk1);
    @(posedge clk); #1;
    in_ready = 1'b0;
    is_last = 1'b0;
    waitFull("s4_block2", n);
    ackBlock();

    $display("[TB] reset during padding");
    doReset();
    applyStimulus(32'h1234_5678, 1'b1, 2'd1);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    f_ack = 1'b1;
    in_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    f_ack = 1'b0;
    in_ready = 1'b0;
    checkOutput("s5_reset_out", out_w, '0);
    checkOutput("s5_reset_full", OW'(buffer_full), '0);
    blk = '0;
    blk = setWord(blk, 0, 32'hCAFE_0100);
    blk = setWord(blk, 17, 32'h0000_0080);
    pushExpected("s5_block", blk);
    applyStimulus(32'hCAFE_F00D, 1'b1, 2'd2);
    waitFull("s5", n);
    ackBlock();

    repeat (3) begin @(posedge clk); #1; end
    checkOutput("scoreboard_drained", OW'(expQ.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
